factorial_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one factorial engine among `NREQ` requesters. It sits between the MMIO-facing request ports and the engine's valid/ready input and output interfaces. It grants one requester at a time, issues its operand to the engine, and captures the result. It then returns that result to the granted requester before re-arbitrating.

---
 rtl/factorial_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_factorial_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/factorial_arbiter.sv
// factorial_arbiter
// Round-robin arbiter that shares one factorial engine among NREQ requesters.
// One request is outstanding at a time: accept, issue to engine, collect the
// result, return it to the granted requester, then re-arbitrate.
// Optional feature macro: FACT_ARB_RANGE_CHECK_EN. When it is defined, operands
// above MAX_X are answered with resp_err=1 and never reach the engine.

module factorial_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int MAX_X = 12
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_x,
    output logic [NREQ-1:0]           resp_valid,
    input  logic [NREQ-1:0]           resp_ready,
    output logic [WIDTH-1:0]          resp_data,
    output logic                      resp_err,
    output logic                      eng_input_valid,
    input  logic                      eng_input_ready,
    output logic [WIDTH-1:0]          eng_x,
    input  logic                      eng_output_valid,
    output logic                      eng_output_ready,
    input  logic [WIDTH-1:0]          eng_factorial,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id
);

    // state | meaning
    // IDLE  | arbitrating; the winner is accepted combinationally this cycle
    // ISSUE | operand offered to the engine, waiting for eng_input_ready
    // WAIT  | engine computing, waiting for the output handshake
    // CAPT  | engine result is on eng_factorial this cycle, latch it
    // RESP  | response held to the granted requester until resp_ready[g]

    localparam int IDW = $clog2(NREQ);

`ifdef FACT_ARB_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CAPT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   grant_id_q;
    logic [WIDTH-1:0] operand_q;
    logic [WIDTH-1:0] resp_data_q;
    logic             resp_err_q;
    logic [NREQ-1:0]  resp_valid_q;
    logic             eng_in_vld_q;
    logic             eng_out_rdy_q;
    logic             busy_q;

    logic [WIDTH-1:0] req_x_a [NREQ];
    logic             arb_found;
    logic [IDW-1:0]   arb_idx;
    logic [IDW:0]     cand;
    logic [NREQ-1:0]  arb_oh;
    logic             over_max;
    logic             out_of_range;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_x_a[i] = req_x[i*WIDTH +: WIDTH];
    end

    // Round-robin scan of req_valid starting at ptr_q, wrapping upward.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!arb_found && req_valid[cand[IDW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[IDW-1:0];
            end
        end
    end

    assign arb_oh       = NREQ'(1) << arb_idx;
    assign over_max     = req_x_a[arb_idx] > WIDTH'(MAX_X);
    assign out_of_range = RANGE_EN && over_max;

    // The accept must land in the same cycle as the scan, so req_ready is combinational.
    assign req_ready = (state_q == S_IDLE && arb_found) ? arb_oh : '0;

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (arb_found) state_d = out_of_range ? S_RESP : S_ISSUE;
            S_ISSUE: if (eng_input_ready) state_d = S_WAIT;
            S_WAIT:  if (eng_output_valid) state_d = S_CAPT;
            S_CAPT:  state_d = S_RESP;
            S_RESP:  if (resp_ready[grant_id_q]) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register plus registered outputs, updated on the transitions that change them.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            grant_id_q    <= '0;
            operand_q     <= '0;
            resp_data_q   <= '0;
            resp_err_q    <= 1'b0;
            resp_valid_q  <= '0;
            eng_in_vld_q  <= 1'b0;
            eng_out_rdy_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (arb_found) begin
                        grant_id_q <= arb_idx;
                        busy_q     <= 1'b1;
                        if (out_of_range) begin
                            // Rejected operands go straight to RESP; the engine is untouched.
                            resp_data_q  <= '0;
                            resp_err_q   <= 1'b1;
                            resp_valid_q <= arb_oh;
                        end else begin
                            operand_q    <= req_x_a[arb_idx];
                            eng_in_vld_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (eng_input_ready) begin
                        eng_in_vld_q  <= 1'b0;
                        eng_out_rdy_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (eng_output_valid) begin
                        eng_out_rdy_q <= 1'b0;
                    end
                end
                S_CAPT: begin
                    // The engine presents its result one cycle after the output handshake.
                    resp_data_q  <= eng_factorial;
                    resp_err_q   <= 1'b0;
                    resp_valid_q <= NREQ'(1) << grant_id_q;
                end
                S_RESP: begin
                    if (resp_ready[grant_id_q]) begin
                        resp_valid_q <= '0;
                        busy_q       <= 1'b0;
                        ptr_q        <= (grant_id_q == IDW'(NREQ-1)) ? '0 : grant_id_q + IDW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_valid       = resp_valid_q;
    assign resp_data        = resp_data_q;
    assign resp_err         = resp_err_q;
    assign eng_input_valid  = eng_in_vld_q;
    assign eng_x            = operand_q;
    assign eng_output_ready = eng_out_rdy_q;
    assign busy             = busy_q;
    assign grant_id         = grant_id_q;

endmodule

// File: tb/tb_factorial_arbiter.sv
// tb_factorial_arbiter
// Random and directed stimulus against a transaction-level reference model
// (round-robin pick, expected-response queue, factorial by plain arithmetic).
// A small behavioural engine with random latency sits on the engine ports.
// Honors FACT_ARB_RANGE_CHECK_EN the same way the design does.

`timescale 1ns/1ps
module tb_factorial_arbiter;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int MAX_X = 12;
    localparam int IDW   = 2;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_x;
    logic [NREQ-1:0]       resp_valid;
    logic [NREQ-1:0]       resp_ready;
    logic [WIDTH-1:0]      resp_data;
    logic                  resp_err;
    logic                  eng_input_valid;
    logic                  eng_input_ready;
    logic [WIDTH-1:0]      eng_x;
    logic                  eng_output_valid;
    logic                  eng_output_ready;
    logic [WIDTH-1:0]      eng_factorial;
    logic                  busy;
    logic [IDW-1:0]        grant_id;

    always #5 clock = ~clock;

    factorial_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_X(MAX_X)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .eng_input_valid(eng_input_valid), .eng_input_ready(eng_input_ready),
        .eng_x(eng_x), .eng_output_valid(eng_output_valid),
        .eng_output_ready(eng_output_ready), .eng_factorial(eng_factorial),
        .busy(busy), .grant_id(grant_id)
    );

    // ---------------- behavioural engine ----------------
    logic             eng_busy = 1'b0;
    logic [WIDTH-1:0] eng_acc = '0;
    logic [WIDTH-1:0] eng_n = '0;
    int               eng_cnt = 0;
    int               eng_hs_count = 0;

    always @(posedge clock) begin
        if (reset) begin
            eng_input_ready  <= 1'b0;
            eng_output_valid <= 1'b0;
            eng_factorial    <= '0;
            eng_busy         <= 1'b0;
            eng_acc          <= '0;
            eng_n            <= '0;
            eng_cnt          <= 0;
        end else begin
            eng_input_ready <= !eng_busy && !(eng_input_valid && eng_input_ready)
                               && ($urandom_range(0, 2) != 0);
            if (eng_input_valid && eng_input_ready) begin
                eng_busy     <= 1'b1;
                eng_acc      <= 1;
                eng_n        <= eng_x;
                eng_cnt      <= $urandom_range(0, 3);
                eng_hs_count <= eng_hs_count + 1;
            end else if (eng_busy && !eng_output_valid) begin
                if (eng_n > 1) begin
                    eng_acc <= eng_acc * eng_n;
                    eng_n   <= eng_n - 1;
                end else if (eng_cnt > 0) begin
                    eng_cnt <= eng_cnt - 1;
                end else begin
                    eng_output_valid <= 1'b1;
                end
            end
            if (eng_output_valid && eng_output_ready) begin
                eng_output_valid <= 1'b0;
                eng_factorial    <= eng_acc;
                eng_busy         <= 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_fact(input logic [WIDTH-1:0] x);
        longint unsigned p = 1;
        for (longint unsigned i = 2; i <= longint'(x); i++) p = (p * i) & 64'hFFFF_FFFF;
        return WIDTH'(p);
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int               g;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] data;
        logic             err;
    } exp_t;

    exp_t             exp_q[$];
    int               served_g[$];
    logic [WIDTH-1:0] served_d[$];
    int               n_served = 0;
    int               ref_ptr = 0;
    bit               ref_busy = 0;
    int               cyc = 0;
    int               hs_cyc = -100;
    int               acc_cyc = -100;
    logic [NREQ-1:0]  prev_rv = '0;
    logic             prev_eiv = 1'b0;
    logic [WIDTH-1:0] held_data = '0;
    logic             held_err = 1'b0;
    logic [NREQ-1:0]  acc_mask = '0;
    logic [NREQ-1:0]  hold = '0;
    bit               rr_random = 1;
    bit               range_en;

    task automatic sample();
        int   g;
        exp_t e;
        if (reset) begin
            exp_q.delete();
            ref_ptr  = 0;
            ref_busy = 0;
            prev_rv  = '0;
            prev_eiv = 1'b0;
            acc_mask = '0;
            return;
        end
        cyc++;
        check("busy", busy, ref_busy);

        g = -1;
        if (!ref_busy)
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && req_valid[(ref_ptr + k) % NREQ]) g = (ref_ptr + k) % NREQ;
        check("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
        acc_mask = req_ready;
        if (g >= 0) begin
            e.g = g;
            e.x = req_x[g*WIDTH +: WIDTH];
            if (range_en && e.x > MAX_X) begin
                e.err  = 1'b1;
                e.data = '0;
            end else begin
                e.err  = 1'b0;
                e.data = ref_fact(e.x);
            end
            exp_q.push_back(e);
            ref_busy = 1;
            acc_cyc  = cyc;
        end

        if (eng_input_valid) begin
            if (exp_q.size() == 0 || exp_q[0].err) check("eng_spurious", eng_input_valid, 0);
            else check("eng_x", eng_x, exp_q[0].x);
            if (!prev_eiv) check("issue_latency", cyc - acc_cyc, 1);
        end
        prev_eiv = eng_input_valid;
        if (eng_output_valid && eng_output_ready) hs_cyc = cyc;

        if (resp_valid != 0) begin
            if (exp_q.size() == 0) begin
                check("resp_spurious", resp_valid, 0);
            end else begin
                if (prev_rv == 0) begin
                    check("resp_latency", exp_q[0].err ? (cyc - acc_cyc) : (cyc - hs_cyc),
                          exp_q[0].err ? 1 : 2);
                    check("resp_valid", resp_valid, 1 << exp_q[0].g);
                    check("resp_data", resp_data, exp_q[0].data);
                    check("resp_err", resp_err, exp_q[0].err);
                    check("grant_id", grant_id, exp_q[0].g);
                    held_data = resp_data;
                    held_err  = resp_err;
                end else begin
                    check("resp_stable", {resp_valid, resp_err, resp_data},
                          {prev_rv, held_err, held_data});
                end
                if (resp_ready[exp_q[0].g]) begin
                    ref_ptr  = (exp_q[0].g + 1) % NREQ;
                    ref_busy = 0;
                    served_g.push_back(exp_q[0].g);
                    served_d.push_back(resp_data);
                    n_served++;
                    void'(exp_q.pop_front());
                end
            end
        end
        prev_rv = resp_valid;
    endtask

    // One clock: sample at the falling edge, then drive just after the rising edge.
    task automatic tick();
        @(negedge clock);
        sample();
        @(posedge clock);
        #1;
        req_valid  = req_valid & ~(acc_mask & ~hold);
        resp_ready = rr_random ? NREQ'($urandom) : '0;
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int b = budget;
        while (n_served < target && b > 0) begin
            tick();
            b--;
        end
        if (n_served < target) check({tag, "_timeout"}, n_served, target);
    endtask

    task automatic drain(input string tag);
        int b = 500;
        while ((exp_q.size() != 0 || req_valid != 0) && b > 0) begin
            tick();
            b--;
        end
        if (exp_q.size() != 0) check({tag, "_drain_timeout"}, exp_q.size(), 0);
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_data"}, resp_data, 0);
        check({tag, "_resp_err"}, resp_err, 0);
        check({tag, "_eng_in_valid"}, eng_input_valid, 0);
        check({tag, "_eng_out_ready"}, eng_output_ready, 0);
        check({tag, "_eng_x"}, eng_x, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_grant_id"}, grant_id, 0);
    endtask

    task automatic set_x(input int i, input int x);
        req_x[i*WIDTH +: WIDTH] = WIDTH'(x);
    endtask

    initial begin
        int base;
        int b;
`ifdef FACT_ARB_RANGE_CHECK_EN
        range_en = 1;
`else
        range_en = 0;
`endif
        reset      = 1'b1;
        req_valid  = '0;
        req_x      = '0;
        resp_ready = '0;
        tick();
        tick();
        check_quiet_outputs("reset");
        reset = 1'b0;
        tick();

        // single request
        set_x(0, 5);
        req_valid = 4'b0001;
        run_until(n_served + 1, 200, "single");
        check("single_data", served_d[served_d.size()-1], 120);

        // contention after reset: served 0,1,2,3
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_x(0, 3); set_x(1, 4); set_x(2, 5); set_x(3, 6);
        req_valid = 4'b1111;
        base = n_served;
        run_until(base + 4, 400, "contention");
        for (int i = 0; i < 4; i++) begin
            if (base + i < served_g.size()) begin
                check("contention_order", served_g[base+i], i);
                check("contention_data", served_d[base+i], ref_fact(WIDTH'(3 + i)));
            end
        end

        // fairness: 0 and 2 held valid
        hold = 4'b0101;
        set_x(0, 4); set_x(2, 4);
        req_valid = 4'b0101;
        base = n_served;
        run_until(base + 4, 400, "fair");
        hold      = '0;
        req_valid = '0;
        for (int i = 0; i < 4; i++)
            if (base + i < served_g.size()) check("fair_order", served_g[base+i], (i % 2) * 2);
        drain("fair");

        // random traffic
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 5) == 0) begin
                    set_x(i, $urandom_range(0, 15));
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            tick();
        end
        req_valid = '0;
        drain("random");

        // backpressure in RESP
        rr_random  = 0;
        resp_ready = '0;
        set_x(1, 7);
        req_valid = 4'b0010;
        b = 200;
        while (resp_valid == 0 && b > 0) begin tick(); b--; end
        if (resp_valid == 0) check("bp_timeout", resp_valid, 4'b0010);
        set_x(3, 2);
        req_valid = req_valid | 4'b1000;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_resp_valid", resp_valid, 4'b0010);
            check("bp_resp_data", resp_data, 5040);
            check("bp_req_ready", req_ready, 0);
            check("bp_eng_in_valid", eng_input_valid, 0);
        end
        rr_random = 1;
        base = n_served;
        run_until(base + 2, 400, "bp");
        if (base + 1 < served_g.size()) check("bp_next_grant", served_g[base+1], 3);
        drain("bp");

        // x=13: range error or truncated 13!
        set_x(2, 13);
        req_valid = 4'b0100;
        base = eng_hs_count;
        run_until(n_served + 1, 200, "range");
        if (range_en) begin
            check("range_data", served_d[served_d.size()-1], 0);
            check("range_engine_untouched", eng_hs_count, base);
        end else begin
            check("range_data", served_d[served_d.size()-1], 32'd1932053504);
        end

        // reset in WAIT, then arbitration restarts from ptr=0
        set_x(1, 3);
        req_valid = 4'b0010;
        run_until(n_served + 1, 200, "pre_rst");
        set_x(2, 6);
        req_valid = 4'b0100;
        b = 200;
        while (!eng_output_ready && b > 0) begin tick(); b--; end
        if (!eng_output_ready) check("rst_wait_timeout", eng_output_ready, 1);
        reset = 1'b1;
        base  = n_served;
        tick();
        reset = 1'b0;
        check_quiet_outputs("rst_wait");
        set_x(1, 0); set_x(3, 9);
        req_valid = 4'b1010;
        run_until(base + 1, 200, "post_rst");
        check("post_rst_grant", served_g[served_g.size()-1], 1);
        check("x0_data", served_d[served_d.size()-1], 1);
        drain("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
